led_frame_builder: RTL and testbench
====================================

LED_FRAME_BUILDER -- requirements
Module: led_frame_builder

Interface
REQ-001 Parameter LEDS, default 50, meaning physical LED count per frame.
REQ-002 Parameter BIN_QTY, default 12, meaning number of note bins.
REQ-003 Parameter CW, default $clog2(LEDS), meaning per-bin count width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 LEDCount_i  input  BIN_QTY x CW  per-bin LED counts from the count stage.
REQ-007 data_v_i  input  1  single-cycle pulse; LEDCount_i valid this cycle.
REQ-008 binColor_i  input  BIN_QTY x 24  per-bin GRB colour.
REQ-009 pixel_o  output  24  current pixel GRB.
REQ-010 pixel_v_o  output  1  pixel_o valid.
REQ-011 pixel_rdy_i  input  1  downstream LED driver accepts pixel.
REQ-012 frame_last_o  output  1  high with the final pixel of a frame.
REQ-013 busy_o  output  1  high from capture until the final pixel is accepted.
REQ-014 overrun_o  output  1  sticky; data_v_i arrived while busy.

Function
REQ-015 States SHALL be IDLE, LOAD, EMIT, FILL; reset state IDLE.
REQ-016 IDLE + data_v_i: capture LEDCount_i and binColor_i into registers, go LOAD, busy_o=1 on the next cycle.
REQ-017 LOAD: bin index=0, pixel counter=0, remaining-in-bin=count[0], one cycle, pixel_v_o=0, then EMIT.
REQ-018 EMIT: pixel_v_o=1 while remaining-in-bin>0; pixel_o=binColor[bin].
REQ-019 Transfer occurs only on pixel_v_o && pixel_rdy_i; each transfer decrements remaining-in-bin and increments pixel counter.
REQ-020 While pixel_v_o && !pixel_rdy_i, pixel_o, pixel_v_o and frame_last_o SHALL hold stable.
REQ-021 Remaining-in-bin reaching 0 for bin < BIN_QTY-2: advance bin and load its count; a zero-count bin costs exactly one cycle with pixel_v_o=0.
REQ-022 After bin BIN_QTY-2 completes: go FILL; the count for bin BIN_QTY-1 is ignored.
REQ-023 FILL: emit binColor[BIN_QTY-1] until pixel counter reaches LEDS.
REQ-024 Cumulative counts exceeding LEDS: emission truncates at pixel LEDS-1; FILL emits no pixels.
REQ-025 Exactly LEDS pixels SHALL be transferred per frame.
REQ-026 frame_last_o=1 only while pixel counter==LEDS-1 and pixel_v_o=1.
REQ-027 On final transfer: next state IDLE, busy_o=0 the next cycle; data_v_i in that same cycle is an overrun.
REQ-028 data_v_i while busy_o=1: ignored, frame in progress unaffected, overrun_o set.

Reset
REQ-029 rst SHALL force IDLE, pixel_v_o=0, frame_last_o=0, busy_o=0, overrun_o=0, pixel_o=0, all counters 0.
REQ-030 rst mid-frame SHALL abort with no further transfers; the next data_v_i starts a fresh frame.

Configuration
REQ-031 Macro LED_FRAME_OFF_FILL_EN defined: last bin emits exactly its own count (clamped), then FILL emits colour 24'h000000 to LEDS.
REQ-032 LED_FRAME_OFF_FILL_EN undefined: behaviour per REQ-022/REQ-023.

Structure
REQ-033 Package cchw_led_pkg SHALL hold the GRB colour typedef (24 bits), the state enum, and constants LEDS and BIN_QTY.
REQ-034 No sub-module; the FSM and counters live in one module.

Verification
REQ-035 Counts [16,0,0,0,0,1,16,0,16,0,0,0], rdy=1 -> 16 x c0, 1 x c5, 16 x c6, 16 x c8, 1 x c11; 50 pixels total; frame_last_o on pixel 49.
REQ-036 Same stimulus with pixel_rdy_i toggled every other cycle -> identical pixel sequence, outputs stable while stalled.
REQ-037 Counts all 10 -> 50 pixels from bins 0-4 only, no c11 pixels, FILL emits none.
REQ-038 Second data_v_i at pixel 20 -> overrun_o=1, frame completes unchanged with 50 pixels.
REQ-039 rst asserted at pixel 30 -> pixel_v_o=0 the next cycle; a new frame then starts cleanly from c0.
REQ-040 With LED_FRAME_OFF_FILL_EN, counts all 0 except count[11]=5 -> 5 x c11 then 45 x 000000.

Source files
------------

// File: rtl/led_frame_builder_pkg.sv
// ============================================================================
// Module      : cchw_led_pkg
// Description : Shared types and constants for the LED frame builder.
//               GRB colour type, frame-builder state encoding, default LED
//               and bin counts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cchw_led_pkg;

    // Default physical LED count per frame and number of note bins.
    localparam int LEDS    = 50;
    localparam int BIN_QTY = 12;

    // One pixel: 8 bits each of green, red, blue (in that order, MSB first).
    typedef logic [23:0] grb_t;

    // Colour pushed during an "off" fill.
    localparam grb_t c_GRB_OFF = 24'h000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        FILL = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/led_frame_builder_if.sv
// ============================================================================
// Module      : led_frame_builder_if
// Description : Pixel stream between the frame builder and the LED driver.
//               Ports:
//                 pixel_o      - current pixel, GRB
//                 pixel_v_o    - pixel_o valid
//                 frame_last_o - final pixel of the frame
//                 pixel_rdy_i  - driver accepts the pixel
//               modport master : frame builder side
//               modport slave  : LED driver side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_frame_builder_if;
    import cchw_led_pkg::*;

    grb_t pixel_o;
    logic pixel_v_o;
    logic frame_last_o;
    logic pixel_rdy_i;

    modport master (
        output pixel_o,
        output pixel_v_o,
        output frame_last_o,
        input  pixel_rdy_i
    );

    modport slave (
        input  pixel_o,
        input  pixel_v_o,
        input  frame_last_o,
        output pixel_rdy_i
    );

endinterface

`default_nettype wire

// File: rtl/led_frame_builder.sv
// ============================================================================
// Module      : led_frame_builder
// Description : Turns a set of per-bin LED counts into a stream of exactly
//               LEDS pixels. Bin b contributes count[b] pixels of colour
//               binColor[b]; the remainder of the strip is filled.
//               Ports:
//                 clk, rst     - clock, synchronous active-high reset
//                 LEDCount_i   - per-bin counts (captured on data_v_i)
//                 data_v_i     - single-cycle capture strobe
//                 binColor_i   - per-bin GRB colours (captured on data_v_i)
//                 pix_if       - pixel stream (master modport)
//                 busy_o       - frame in progress
//                 overrun_o    - sticky: strobe arrived while busy
//               Build option LED_FRAME_OFF_FILL_EN: when defined the last
//               bin emits its own count and the fill colour is black;
//               otherwise the last bin's colour fills the remainder and
//               its count is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_frame_builder #(
    parameter int LEDS    = cchw_led_pkg::LEDS,
    parameter int BIN_QTY = cchw_led_pkg::BIN_QTY,
    parameter int CW      = $clog2(LEDS)
) (
    input  wire logic                             clk,
    input  wire logic                             rst,
    input  wire logic [BIN_QTY-1:0][CW-1:0]       LEDCount_i,
    input  wire logic                             data_v_i,
    input  wire cchw_led_pkg::grb_t [BIN_QTY-1:0] binColor_i,
    led_frame_builder_if.master                   pix_if,
    output logic                                  busy_o,
    output logic                                  overrun_o
);
    import cchw_led_pkg::*;

    localparam int BW = $clog2(BIN_QTY);
    localparam int PW = $clog2(LEDS + 1);

    // Highest bin walked in EMIT; anything past it comes from FILL.
`ifdef LED_FRAME_OFF_FILL_EN
    localparam int LAST_EMIT_BIN = BIN_QTY - 1;
`else
    localparam int LAST_EMIT_BIN = BIN_QTY - 2;
`endif

    localparam logic [BW-1:0] c_LAST_BIN = BW'(LAST_EMIT_BIN);
    localparam logic [PW-1:0] c_LAST_PIX = PW'(LEDS - 1);

    state_t                      state_q, state_d;
    logic [BIN_QTY-1:0][CW-1:0]  cnt_q,   cnt_d;
    grb_t [BIN_QTY-1:0]          col_q,   col_d;
    logic [BW-1:0]               bin_q,   bin_d;
    logic [PW-1:0]               pix_q,   pix_d;
    logic [CW-1:0]               rem_q,   rem_d;
    logic                        busy_q,  busy_d;
    logic                        ovr_q,   ovr_d;

    grb_t                        w_pixel;
    grb_t                        w_fill_col;
    logic                        w_pixel_v;
    logic                        w_last;
    logic [BW-1:0]               w_bin_nxt;

`ifdef LED_FRAME_OFF_FILL_EN
    assign w_fill_col = c_GRB_OFF;
`else
    assign w_fill_col = col_q[BIN_QTY-1];
`endif

    assign w_bin_nxt = bin_q + BW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            bin_q   <= '0;
            pix_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            bin_q   <= bin_d;
            pix_q   <= pix_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        bin_d     = bin_q;
        pix_d     = pix_q;
        rem_d     = rem_q;
        busy_d    = busy_q;
        ovr_d     = ovr_q;
        w_pixel   = '0;
        w_pixel_v = 1'b0;
        w_last    = 1'b0;

        // busy_q covers LOAD/EMIT/FILL and the cycle of the final transfer.
        if (data_v_i && busy_q) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (data_v_i) begin
                    cnt_d   = LEDCount_i;
                    col_d   = binColor_i;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                bin_d   = '0;
                pix_d   = '0;
                rem_d   = cnt_q[0];
                state_d = EMIT;
            end

            EMIT: begin
                w_pixel = col_q[bin_q];
                if (rem_q != '0) begin
                    w_pixel_v = 1'b1;
                    w_last    = (pix_q == c_LAST_PIX);
                    if (pix_if.pixel_rdy_i) begin
                        if (w_last) begin
                            // Strip full: any leftover counts are truncated.
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            pix_d = pix_q + PW'(1);
                            if (rem_q == CW'(1)) begin
                                // Bin drained on this transfer: move on
                                // without a bubble cycle.
                                if (bin_q == c_LAST_BIN) begin
                                    rem_d   = '0;
                                    state_d = FILL;
                                end else begin
                                    bin_d = w_bin_nxt;
                                    rem_d = cnt_q[w_bin_nxt];
                                end
                            end else begin
                                rem_d = rem_q - CW'(1);
                            end
                        end
                    end
                end else begin
                    // Zero-count bin: one idle cycle, then advance.
                    if (bin_q == c_LAST_BIN) begin
                        state_d = FILL;
                    end else begin
                        bin_d = w_bin_nxt;
                        rem_d = cnt_q[w_bin_nxt];
                    end
                end
            end

            FILL: begin
                // Every non-final transfer leaves pix_q below LEDS, so FILL
                // always has at least one pixel to send.
                w_pixel   = w_fill_col;
                w_pixel_v = 1'b1;
                w_last    = (pix_q == c_LAST_PIX);
                if (pix_if.pixel_rdy_i) begin
                    if (w_last) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        pix_d = pix_q + PW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pix_if.pixel_o      = w_pixel;
    assign pix_if.pixel_v_o    = w_pixel_v;
    assign pix_if.frame_last_o = w_last;
    assign busy_o              = busy_q;
    assign overrun_o           = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_led_frame_builder.sv
// ============================================================================
// Module      : tb_led_frame_builder
// Description : Self-checking bench for led_frame_builder. A monitor logs
//               every accepted pixel; each frame is compared against a
//               list of pixels built directly from the count/colour rules.
//               Honours LED_FRAME_OFF_FILL_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_frame_builder;
    import cchw_led_pkg::*;

    localparam int NL  = LEDS;
    localparam int NB  = BIN_QTY;
    localparam int CWB = $clog2(NL);

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NB-1:0][CWB-1:0]     cnt_v;
    logic                       data_v;
    grb_t [NB-1:0]              col_v;
    logic                       busy;
    logic                       ovr;

    led_frame_builder_if pif ();

    led_frame_builder dut (
        .clk        (clk),
        .rst        (rst),
        .LEDCount_i (cnt_v),
        .data_v_i   (data_v),
        .binColor_i (col_v),
        .pix_if     (pif),
        .busy_o     (busy),
        .overrun_o  (ovr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- ready generation ----------------
    int rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random
    initial begin
        pif.pixel_rdy_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       pif.pixel_rdy_i = 1'b1;
                1:       pif.pixel_rdy_i = ~pif.pixel_rdy_i;
                default: pif.pixel_rdy_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor ----------------
    grb_t got_pix[$];
    bit   got_last[$];
    grb_t prev_pix;
    logic prev_v, prev_last;
    bit   prev_stall = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall)
                check_val("stall_hold", {6'd0, pif.pixel_o, pif.pixel_v_o, pif.frame_last_o},
                          {6'd0, prev_pix, prev_v, prev_last});
            if (pif.frame_last_o)
                check_val("last_needs_valid", 32'(pif.pixel_v_o), 32'd1);
            if (pif.pixel_v_o && pif.pixel_rdy_i) begin
                got_pix.push_back(pif.pixel_o);
                got_last.push_back(pif.frame_last_o);
            end
            prev_stall = pif.pixel_v_o && !pif.pixel_rdy_i;
            prev_pix   = pif.pixel_o;
            prev_v     = pif.pixel_v_o;
            prev_last  = pif.frame_last_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    int   cnt_a[NB];
    grb_t col_a[NB];
    grb_t exp_q[$];

    // Concatenate bin runs in order, cut at NL, pad with the fill colour.
    task automatic build_expected();
        int   last_bin;
        grb_t fill;
`ifdef LED_FRAME_OFF_FILL_EN
        last_bin = NB - 1;
        fill     = 24'h000000;
`else
        last_bin = NB - 2;
        fill     = col_a[NB-1];
`endif
        exp_q.delete();
        for (int b = 0; b <= last_bin; b++)
            for (int k = 0; k < cnt_a[b]; k++)
                if (exp_q.size() < NL) exp_q.push_back(col_a[b]);
        while (exp_q.size() < NL) exp_q.push_back(fill);
    endtask

    task automatic rand_cols();
        for (int b = 0; b < NB; b++) col_a[b] = {8'(b + 1), 16'($urandom)};
    endtask

    task automatic rand_cnts(input int hi);
        for (int b = 0; b < NB; b++) cnt_a[b] = $urandom_range(0, hi);
    endtask

    // ---------------- frame helpers ----------------
    task automatic start_frame();
        build_expected();
        got_pix.delete();
        got_last.delete();
        @(posedge clk);
        #1;
        for (int b = 0; b < NB; b++) begin
            cnt_v[b] = CWB'(cnt_a[b]);
            col_v[b] = col_a[b];
        end
        data_v = 1'b1;
        @(posedge clk);
        #1;
        data_v = 1'b0;
        // Scramble inputs: the design must work from its captured copy.
        for (int b = 0; b < NB; b++) begin
            cnt_v[b] = CWB'($urandom);
            col_v[b] = grb_t'($urandom);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_done_in_time"}, 32'(n < 5000), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_pixels(input string tag, input int target);
        int n = 0;
        while (got_pix.size() < target && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check_val({tag, "_reached"}, 32'(n < 5000), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        check_val({tag, "_count"}, 32'(got_pix.size()), 32'(NL));
        for (int i = 0; i < got_pix.size() && i < NL; i++) begin
            check_val($sformatf("%s_pix%0d", tag, i), 32'(got_pix[i]), 32'(exp_q[i]));
            check_val($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i == NL - 1));
        end
    endtask

    task automatic run_frame(input string tag);
        start_frame();
        wait_idle(tag);
        check_frame(tag);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst    = 1'b1;
        data_v = 1'b0;
        cnt_v  = '0;
        col_v  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_pixel_v", 32'(pif.pixel_v_o), 32'd0);
        check_val("rst_last", 32'(pif.frame_last_o), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_overrun", 32'(ovr), 32'd0);
        check_val("rst_pixel", 32'(pif.pixel_o), 32'd0);

        // Mixed counts including zero bins, always ready.
        rand_cols();
        cnt_a = '{16, 0, 0, 0, 0, 1, 16, 0, 16, 0, 0, 0};
        rdy_mode = 0;
        run_frame("mixed");
        check_val("mixed_overrun", 32'(ovr), 32'd0);

        // Same counts with ready toggling every cycle.
        rdy_mode = 1;
        run_frame("mixed_stall");
        rdy_mode = 0;

        // Over-full: truncation inside the emit phase.
        rand_cols();
        for (int b = 0; b < NB; b++) cnt_a[b] = 10;
        run_frame("all10");

        // Second strobe mid-frame.
        rand_cols();
        rand_cnts(6);
        start_frame();
        wait_pixels("ovr", 20);
        #1;
        for (int b = 0; b < NB; b++) cnt_v[b] = CWB'(1);
        data_v = 1'b1;
        @(posedge clk);
        #1;
        data_v = 1'b0;
        wait_idle("ovr");
        check_frame("ovr");
        check_val("ovr_sticky", 32'(ovr), 32'd1);

        // Reset in the middle of a frame.
        rand_cols();
        rand_cnts(8);
        start_frame();
        wait_pixels("rstmid", 30);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rstmid_pixel_v", 32'(pif.pixel_v_o), 32'd0);
        check_val("rstmid_busy", 32'(busy), 32'd0);
        check_val("rstmid_overrun", 32'(ovr), 32'd0);
        repeat (5) @(negedge clk);
        check_val("rstmid_abort_count", 32'(got_pix.size()), 32'd30);
        rand_cols();
        rand_cnts(8);
        run_frame("after_rst");

        // Only the last bin populated.
        rand_cols();
        for (int b = 0; b < NB; b++) cnt_a[b] = 0;
        cnt_a[NB-1] = 5;
        run_frame("lastonly");

        // Randomised frames with random backpressure.
        for (int f = 0; f < 6; f++) begin
            rand_cols();
            rand_cnts(f < 3 ? 9 : 20);
            rdy_mode = 2;
            run_frame($sformatf("rand%0d", f));
        end
        rdy_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
